trap_setup: RTL and testbench

TRAP_SETUP -- requirements
Module: trap_setup

---
 rtl/trap_setup.sv | 165 ++++++++++++++++
 tb/tb_trap_setup.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/trap_setup.sv
// Trapezoid setup stage: collects six vertex bytes, derives the edge
// coefficients a/b1/b2 and constants c1/c2 with one shared shift-add
// multiplier, then holds them while the scanline search runs.
// Optional macro SETUP_ORDER_CHECK_EN enables the sticky vertex-order error.
module trap_setup (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  din,
  input  logic        din_valid,
  input  logic        render_done,
  output logic        ready,
  output logic [7:0]  xul,
  output logic [7:0]  xur,
  output logic [7:0]  xdl,
  output logic [7:0]  xdr,
  output logic [7:0]  yu,
  output logic [7:0]  yd,
  output logic [8:0]  a,
  output logic [8:0]  b1,
  output logic [8:0]  b2,
  output logic [18:0] c1,
  output logic [18:0] c2,
  output logic        state_start,
  output logic        nt,
  output logic        err
);

  typedef enum logic [2:0] {StIdle, StLoad, StDiff, StMul, StRun, StFin} state_e;

  state_e      state_q, state_d;
  logic [2:0]  byte_cnt;
  logic [4:0]  mul_cnt;
  logic        accept;
  logic        order_bad;
  logic [8:0]  mcand;
  logic [7:0]  mplier;
  logic [18:0] pp;

  assign ready       = (state_q == StIdle) || (state_q == StLoad);
  assign state_start = (state_q == StRun);
  assign nt          = (state_q == StFin);
  assign accept      = ready && din_valid;

`ifdef SETUP_ORDER_CHECK_EN
  assign order_bad = (yu < yd) || (xul > xur) || (xdl > xdr);

  // Sticky error: set by a bad vertex order, cleared by the next first byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (accept && (byte_cnt == 3'd0)) begin
      err <= 1'b0;
    end else if ((state_q == StDiff) && order_bad) begin
      err <= 1'b1;
    end
  end
`else
  assign order_bad = 1'b0;
  assign err       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StLoad: begin
        if (accept) begin
          state_d = (byte_cnt == 3'd5) ? StDiff : StLoad;
        end
      end
      StDiff: state_d = order_bad ? StIdle : StMul;
      StMul: begin
        if (mul_cnt == 5'd31) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (render_done) begin
          state_d = StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Partial product: product index in mul_cnt[4:3], multiplier bit in mul_cnt[2:0]
  always_comb begin
    mcand  = a;
    mplier = xdl;
    case (mul_cnt[4:3])
      2'd0: begin mcand = a;  mplier = xdl; end
      2'd1: begin mcand = b1; mplier = yd;  end
      2'd2: begin mcand = a;  mplier = xdr; end
      default: begin mcand = b2; mplier = yd; end
    endcase
    pp = '0;
    if (mplier[mul_cnt[2:0]]) begin
      pp = {{10{mcand[8]}}, mcand} << mul_cnt[2:0];
    end
  end

  // Datapath: byte capture, differences, and negated product accumulation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= 3'd0;
      mul_cnt  <= 5'd0;
      xul      <= 8'd0;
      xur      <= 8'd0;
      xdl      <= 8'd0;
      xdr      <= 8'd0;
      yu       <= 8'd0;
      yd       <= 8'd0;
      a        <= 9'd0;
      b1       <= 9'd0;
      b2       <= 9'd0;
      c1       <= 19'd0;
      c2       <= 19'd0;
    end else begin
      case (state_q)
        StIdle, StLoad: begin
          if (din_valid) begin
            case (byte_cnt)
              3'd0:    xul <= {1'b0, din[6:0]};
              3'd1:    xur <= {1'b0, din[6:0]};
              3'd2:    xdl <= {1'b0, din[6:0]};
              3'd3:    xdr <= {1'b0, din[6:0]};
              3'd4:    yu  <= {1'b0, din[6:0]};
              default: yd  <= {1'b0, din[6:0]};
            endcase
            byte_cnt <= (byte_cnt == 3'd5) ? 3'd0 : byte_cnt + 3'd1;
          end
        end
        StDiff: begin
          a       <= {1'b0, yu} - {1'b0, yd};
          b1      <= {1'b0, xdl} - {1'b0, xul};
          b2      <= {1'b0, xdr} - {1'b0, xur};
          c1      <= 19'd0;
          c2      <= 19'd0;
          mul_cnt <= 5'd0;
        end
        StMul: begin
          // Subtracting builds c = -(sum of products) directly
          if (mul_cnt[4]) begin
            c2 <= c2 - pp;
          end else begin
            c1 <= c1 - pp;
          end
          mul_cnt <= mul_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_setup.sv
// Directed self-checking bench for trap_setup.
module tb_trap_setup;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  din = 8'd0;
  logic        din_valid = 1'b0;
  logic        render_done = 1'b0;
  logic        ready;
  logic [7:0]  xul, xur, xdl, xdr, yu, yd;
  logic [8:0]  a, b1, b2;
  logic [18:0] c1, c2;
  logic        state_start, nt, err;

  int n_cmp = 0;
  int n_bad = 0;

  trap_setup dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .render_done(render_done), .ready(ready),
    .xul(xul), .xur(xur), .xdl(xdl), .xdr(xdr), .yu(yu), .yd(yd),
    .a(a), .b1(b1), .b2(b2), .c1(c1), .c2(c2),
    .state_start(state_start), .nt(nt), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bytes packed msb-first: xul, xur, xdl, xdr, yu, yd
  task automatic load6(input logic [47:0] v, input bit gaps);
    for (int i = 0; i < 6; i++) begin
      if (gaps && i > 0) begin
        @(negedge clk);
        din_valid = 1'b0;
        din = 8'hEE;
      end
      @(negedge clk);
      din = v[47 - 8*i -: 8];
      din_valid = 1'b1;
    end
  endtask

  // Called right after the sixth byte is driven; checks the 34-cycle latency
  task automatic wait_run(input bit junk);
    @(negedge clk);
    chk("ready_in_diff", {31'd0, ready}, 32'd0);
    din_valid = junk;
    din = 8'h7F;
    render_done = junk;
    repeat (32) @(negedge clk);
    din_valid = 1'b0;
    render_done = 1'b0;
    chk("start_at_33", {31'd0, state_start}, 32'd0);
    @(negedge clk);
    chk("start_at_34", {31'd0, state_start}, 32'd1);
  endtask

  task automatic finish_trap();
    @(negedge clk);
    render_done = 1'b1;
    @(negedge clk);
    render_done = 1'b0;
    chk("fin_nt", {31'd0, nt}, 32'd1);
    chk("fin_start", {31'd0, state_start}, 32'd0);
    chk("fin_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    chk("after_fin_nt", {31'd0, nt}, 32'd0);
    chk("after_fin_ready", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_start", {31'd0, state_start}, 32'd0);
    chk("rst_nt", {31'd0, nt}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_c1", {13'd0, c1}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Trapezoid 20,40,10,50,30,10 (bit 7 set on first byte must be dropped)
    load6({8'd148, 8'd40, 8'd10, 8'd50, 8'd30, 8'd10}, 1'b0);
    wait_run(1'b0);
    chk("t1_xul", {24'd0, xul}, 32'd20);
    chk("t1_xdr", {24'd0, xdr}, 32'd50);
    chk("t1_a", {23'd0, a}, 32'd20);
    chk("t1_b1", {23'd0, b1}, 32'h1F6);   // -10
    chk("t1_b2", {23'd0, b2}, 32'h00A);
    chk("t1_c1", {13'd0, c1}, 32'h7FF9C); // -100
    chk("t1_c2", {13'd0, c2}, 32'h7FBB4); // -1100
    repeat (3) @(negedge clk);
    chk("t1_hold_start", {31'd0, state_start}, 32'd1);
    chk("t1_hold_c2", {13'd0, c2}, 32'h7FBB4);
    finish_trap();

    // Rectangle with input gaps, junk bytes and render_done during MUL
    load6({8'd5, 8'd60, 8'd5, 8'd60, 8'd50, 8'd0}, 1'b1);
    wait_run(1'b1);
    chk("t2_xur", {24'd0, xur}, 32'd60);
    chk("t2_yd", {24'd0, yd}, 32'd0);
    chk("t2_a", {23'd0, a}, 32'd50);
    chk("t2_b1", {23'd0, b1}, 32'd0);
    chk("t2_b2", {23'd0, b2}, 32'd0);
    chk("t2_c1", {13'd0, c1}, 32'h7FF06); // -250
    chk("t2_c2", {13'd0, c2}, 32'h7F448); // -3000
    finish_trap();

    // Reset in MUL cycle 15 discards everything
    load6({8'd20, 8'd40, 8'd10, 8'd50, 8'd30, 8'd10}, 1'b0);
    @(negedge clk);
    din_valid = 1'b0;
    repeat (16) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_ready", {31'd0, ready}, 32'd1);
    chk("mrst_nt", {31'd0, nt}, 32'd0);
    chk("mrst_a", {23'd0, a}, 32'd0);
    chk("mrst_b1", {23'd0, b1}, 32'd0);
    chk("mrst_c1", {13'd0, c1}, 32'd0);
    chk("mrst_xdr", {24'd0, xdr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    load6({8'd20, 8'd40, 8'd10, 8'd50, 8'd30, 8'd10}, 1'b0);
    wait_run(1'b0);
    chk("t3_c1", {13'd0, c1}, 32'h7FF9C);
    chk("t3_c2", {13'd0, c2}, 32'h7FBB4);
    finish_trap();

    // Reversed top edge
    load6({8'd40, 8'd20, 8'd10, 8'd50, 8'd30, 8'd10}, 1'b0);
`ifdef SETUP_ORDER_CHECK_EN
    @(negedge clk);
    din_valid = 1'b0;
    @(negedge clk);
    chk("ord_err", {31'd0, err}, 32'd1);
    chk("ord_start", {31'd0, state_start}, 32'd0);
    chk("ord_ready", {31'd0, ready}, 32'd1);
    repeat (40) @(negedge clk);
    chk("ord_start_late", {31'd0, state_start}, 32'd0);
    chk("ord_err_sticky", {31'd0, err}, 32'd1);
    load6({8'd20, 8'd40, 8'd10, 8'd50, 8'd30, 8'd10}, 1'b0);
    chk("ord_err_hold", {31'd0, err}, 32'd0);
    wait_run(1'b0);
    chk("t4_c2", {13'd0, c2}, 32'h7FBB4);
    finish_trap();
`else
    wait_run(1'b0);
    chk("t4_err", {31'd0, err}, 32'd0);
    chk("t4_b1", {23'd0, b1}, 32'h1E2);   // -30
    chk("t4_b2", {23'd0, b2}, 32'h01E);
    chk("t4_c1", {13'd0, c1}, 32'h00064); // 100
    chk("t4_c2", {13'd0, c2}, 32'h7FAEC); // -1300
    finish_trap();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
